uart_tx_arbiter: RTL and testbench

Shares the single UART transmit path between several on-badge requesters, such as challenge blocks or a debug dump, that each want to emit a fixed-length frame. Each request is granted round-robin, and the winner's frame is latched. The frame is streamed byte-by-byte into the UART core's TX FIFO write port, and a programmable quiet gap is enforced between frames. The block sits in `top` between the challenge blocks and `uart_top`, replacing the hard-wired `tx_trigger`/`tx_in` drive.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: the FSM state encoding,
// the default byte width and the byte-index width.
package uart_arb_pkg;

  localparam int DEFAULT_DBITS = 8;
  localparam int IDX_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector. The search begins one position after
// last_winner and wraps around; the first requesting index wins.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic [REQ_W-1:0]   winner_idx
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pool;

  // Prefer requesters above last_winner; fall back to the whole set to wrap.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = (i > int'(last_winner));
    end
    masked     = req & upper;
    pool       = (|masked) ? masked : req;
    winner     = '0;
    winner_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pool[i]) begin
        winner     = '0;
        winner[i]  = 1'b1;
        winner_idx = REQ_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several requesters share one UART TX FIFO
// write port. The winning requester's fixed-length frame is latched and
// streamed MSB-byte first, followed by a programmable quiet gap.
// Optional feature: define UART_ARB_NUL_STRIP_EN to skip 0x00 bytes of the
// latched frame instead of transmitting them.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DBITS       = DEFAULT_DBITS,
  parameter int FRAME_BYTES = 18,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*FRAME_BYTES*DBITS-1:0] frame_in,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [NUM_REQ-1:0]                 done,
  output logic                               busy,
  output logic [DBITS-1:0]                   tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready
);

  localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FRAME_W = FRAME_BYTES * DBITS;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BYTES - 1);
  localparam logic [7:0]       GAP_INIT   = 8'(GAP_CYCLES);
  localparam arb_state_t       POST_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

`ifdef UART_ARB_NUL_STRIP_EN
  localparam bit NUL_STRIP = 1'b1;
`else
  localparam bit NUL_STRIP = 1'b0;
`endif

  arb_state_t         state;
  arb_state_t         state_next;
  logic [REQ_W-1:0]   last_winner;
  logic [REQ_W-1:0]   win_idx;
  logic [REQ_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] slice_sel;
  logic [DBITS-1:0]   first_byte;
  logic [DBITS-1:0]   next_byte;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [7:0]         gap_cnt;
  logic               xfer;
  logic               free;
  logic               finish;
  logic               latch_finish;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .winner      (pick_onehot),
    .winner_idx  (pick_idx)
  );

  // Select the winner's frame slice out of the flat frame bus.
  always_comb begin
    slice_sel = frame_in[FRAME_W-1:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (win_idx == REQ_W'(i)) slice_sel = frame_in[i*FRAME_W +: FRAME_W];
    end
  end

  assign first_byte = slice_sel[FRAME_W-1 -: DBITS];
  assign idx_inc    = idx + 1'b1;

  // Fetch the byte after the current one from the latched frame.
  always_comb begin
    next_byte = '0;
    for (int b = 0; b < FRAME_BYTES; b++) begin
      if (idx_inc == IDX_W'(b)) next_byte = frame_q[(FRAME_BYTES-1-b)*DBITS +: DBITS];
    end
  end

  // A slot is free when the current byte is accepted, or (when stripping)
  // when it is a skipped NUL. A trailing NUL can end the frame early.
  assign xfer   = tx_valid && tx_ready;
  assign free   = xfer || (NUL_STRIP && !tx_valid);
  assign finish = (state == ST_SEND) && free &&
                  ((idx == LAST_IDX) ||
                   (NUL_STRIP && (idx_inc == LAST_IDX) && (next_byte == '0)));
  assign latch_finish = NUL_STRIP && (FRAME_BYTES == 1) && (first_byte == '0);

  // State register.
  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (|req) state_next = ST_LATCH;
      ST_LATCH: state_next = latch_finish ? POST_FRAME : ST_SEND;
      ST_SEND:  if (finish) state_next = POST_FRAME;
      ST_GAP:   if (gap_cnt == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Frame holding register, written once per frame in LATCH.
  // NOTE: no reset here; the frame is always overwritten in LATCH before any
  // byte of it is read.
  always_ff @(posedge clk) begin
    if (state == ST_LATCH) frame_q <= slice_sel;
  end

  // Registered outputs, arbitration history, byte index and gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      idx         <= '0;
      gap_cnt     <= '0;
      win_idx     <= '0;
      last_winner <= REQ_W'(NUM_REQ - 1);
    end else begin
      done <= '0;
      busy <= (state_next != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            win_idx <= pick_idx;
            grant   <= pick_onehot;
          end
        end
        ST_LATCH: begin
          last_winner <= win_idx;
          idx         <= '0;
          tx_data     <= first_byte;
          if (latch_finish) begin
            tx_valid <= 1'b0;
            done     <= grant;
            grant    <= '0;
            gap_cnt  <= GAP_INIT;
          end else begin
            tx_valid <= NUL_STRIP ? (first_byte != '0) : 1'b1;
          end
        end
        ST_SEND: begin
          if (finish) begin
            tx_valid <= 1'b0;
            done     <= grant;
            grant    <= '0;
            gap_cnt  <= GAP_INIT;
          end else if (free) begin
            idx      <= idx_inc;
            tx_data  <= next_byte;
            tx_valid <= NUL_STRIP ? (next_byte != '0) : 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. The stimulus process predicts each
// frame (winner, byte stream, length) with a simple round-robin model and
// queues it; a negedge monitor compares whatever the DUT presents.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int DB      = 8;
  localparam int FB      = 18;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 2000;

`ifdef UART_ARB_NUL_STRIP_EN
  localparam bit STRIP    = 1'b1;
  localparam int DONE_LAT = FB + 1;
`else
  localparam bit STRIP    = 1'b0;
  localparam int DONE_LAT = FB + 2;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*FB*DB-1:0] frame_in = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              busy;
  logic [DB-1:0]     tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DBITS       (DB),
    .FRAME_BYTES (FB),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .frame_in (frame_in),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state and scoreboard queues.
  logic [7:0]   fr [N][FB];
  int           last_w = N - 1;
  logic [N-1:0] exp_grant_q [$];
  logic [N-1:0] exp_done_q  [$];
  logic [7:0]   exp_byte_q  [$];
  int           exp_len_q   [$];

  function automatic int rr_model(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last_w + k) % N]) return (last_w + k) % N;
    end
    return -1;
  endfunction

  task automatic push_frame(input logic [N-1:0] r);
    int w;
    int n;
    w = rr_model(r);
    last_w = w;
    exp_grant_q.push_back(N'(1) << w);
    exp_done_q.push_back(N'(1) << w);
    n = 0;
    for (int j = 0; j < FB; j++) begin
      if (!STRIP || fr[w][j] != 8'h00) begin
        exp_byte_q.push_back(fr[w][j]);
        n++;
      end
    end
    exp_len_q.push_back(n);
  endtask

  task automatic rand_frames(input bit allow_zero);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < FB; j++)
        fr[i][j] = (allow_zero && $urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  task automatic apply_frames();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < FB; j++)
        frame_in[(i*FB + (FB-1-j))*DB +: DB] = fr[i][j];
  endtask

  // Cycle counter and monitor bookkeeping.
  int  cyc = 0;
  int  grant_cnt = 0;
  int  done_cnt = 0;
  int  frame_xfers = 0;
  int  last_done_cyc = 0;
  int  lat_base = 0;
  bit  lat_check = 1'b0;
  bit  gap_check_en = 1'b0;
  int  rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready driver: always ready, 1,0,0 pattern, or random.
  initial begin
    int pcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       tx_ready = (pcnt % 3 == 0);
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
      pcnt++;
    end
  end

  // Monitor: compares DUT activity against the queued expectations.
  logic [N-1:0]  prev_grant = '0;
  bit            stall_prev = 1'b0;
  logic [DB-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_grant  = '0;
      stall_prev  = 1'b0;
      frame_xfers = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(stall_data));
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;

      if (grant != '0 && prev_grant == '0) begin
        grant_cnt++;
        check("grant_expected", 32'(exp_grant_q.size() > 0), 32'd1);
        if (exp_grant_q.size() > 0) check("grant", 32'(grant), 32'(exp_grant_q.pop_front()));
        check("busy_at_grant", 32'(busy), 32'd1);
        if (lat_check) check("grant_latency", 32'(cyc - lat_base), 32'd1);
        if (gap_check_en) check("gap_len", 32'(cyc - last_done_cyc), 32'(GAP + 2));
      end

      if (tx_valid && tx_ready) begin
        frame_xfers++;
        check("byte_expected", 32'(exp_byte_q.size() > 0), 32'd1);
        if (exp_byte_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_byte_q.pop_front()));
      end

      if (done != '0) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_expected", 32'(exp_done_q.size() > 0), 32'd1);
        if (exp_done_q.size() > 0) check("done", 32'(done), 32'(exp_done_q.pop_front()));
        if (exp_len_q.size() > 0) check("frame_len", 32'(frame_xfers), 32'(exp_len_q.pop_front()));
        check("grant_low_at_done", 32'(grant), 32'd0);
        check("valid_low_at_done", 32'(tx_valid), 32'd0);
        if (lat_check) check("done_latency", 32'(cyc - lat_base), 32'(DONE_LAT));
        frame_xfers = 0;
      end
      prev_grant = grant;
    end
  end

  // Bounded waits; an expired bound counts as a failed comparison.
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < TIMEOUT) begin @(negedge clk); t++; end
    check("wait_idle_in_time", 32'(t < TIMEOUT), 32'd1);
  endtask

  task automatic wait_grants(input int target);
    int t = 0;
    while (grant_cnt < target && t < TIMEOUT) begin @(negedge clk); t++; end
    check("wait_grant_in_time", 32'(grant_cnt >= target), 32'd1);
  endtask

  task automatic wait_dones(input int target);
    int t = 0;
    while (done_cnt < target && t < TIMEOUT) begin @(negedge clk); t++; end
    check("wait_done_in_time", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_xfers(input int n);
    int t = 0;
    while (frame_xfers < n && t < TIMEOUT) begin @(negedge clk); t++; end
    check("wait_xfer_in_time", 32'(frame_xfers >= n), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},    32'(grant),    32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0] r;
    int gt;
    int dt;

    // Reset state.
    rand_frames(1'b0);
    apply_frames();
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Contention: all four requesting, expected order 0,1,2,3 with full gaps.
    wait_idle();
    req = '1;
    for (int k = 0; k < 4; k++) push_frame(req);
    gt = grant_cnt;
    dt = done_cnt;
    wait_grants(gt + 1);
    gap_check_en = 1'b1;
    wait_grants(gt + 4);
    gap_check_en = 1'b0;
    req = '0;
    wait_dones(dt + 4);

    // Single request with a short zero-padded string; timing checked.
    rand_frames(1'b0);
    for (int j = 0; j < FB; j++) fr[0][j] = 8'h00;
    if (STRIP) begin
      fr[0][0] = 8'h41; fr[0][1] = 8'h42;
    end else begin
      fr[0][0] = 8'h7b; fr[0][1] = 8'h68; fr[0][2] = 8'h69; fr[0][3] = 8'h7d;
    end
    apply_frames();
    wait_idle();
    lat_base  = cyc;
    lat_check = 1'b1;
    req = 4'b0001;
    push_frame(req);
    gt = grant_cnt;
    dt = done_cnt;
    wait_grants(gt + 1);
    @(posedge clk); #1;
    req = '0;
    wait_dones(dt + 1);
    lat_check = 1'b0;

    // Backpressure with a 1,0,0 ready pattern.
    rdy_mode = 1;
    rand_frames(1'b0);
    apply_frames();
    wait_idle();
    req = 4'b1000;
    push_frame(req);
    gt = grant_cnt;
    dt = done_cnt;
    wait_grants(gt + 1);
    @(posedge clk); #1;
    req = '0;
    rand_frames(1'b0);
    apply_frames();
    wait_dones(dt + 1);
    rdy_mode = 0;

    // Requester 2 drops its request mid-frame.
    rand_frames(1'b0);
    apply_frames();
    wait_idle();
    req = 4'b0100;
    push_frame(req);
    gt = grant_cnt;
    dt = done_cnt;
    wait_grants(gt + 1);
    wait_xfers(5);
    req = '0;
    wait_dones(dt + 1);

    // Reset in the middle of a frame.
    rand_frames(1'b0);
    apply_frames();
    wait_idle();
    req = 4'b0001;
    push_frame(req);
    gt = grant_cnt;
    wait_grants(gt + 1);
    wait_xfers(7);
    #2;
    reset_n = 1'b0;
    req = '0;
    #1;
    check_all_zero("mid_frame_reset");
    exp_grant_q.delete();
    exp_done_q.delete();
    exp_byte_q.delete();
    exp_len_q.delete();
    last_w = N - 1;
    repeat (2) @(negedge clk);
    check_all_zero("held_reset");
    reset_n = 1'b1;
    rand_frames(1'b0);
    apply_frames();
    wait_idle();
    req = 4'b0010;
    push_frame(req);
    gt = grant_cnt;
    dt = done_cnt;
    wait_grants(gt + 1);
    @(posedge clk); #1;
    req = '0;
    wait_dones(dt + 1);

    // Randomized requests, frames and ready behaviour.
    for (int it = 0; it < 10; it++) begin
      rdy_mode = $urandom_range(0, 2);
      rand_frames(1'b1);
      apply_frames();
      wait_idle();
      r = N'($urandom_range(1, (1 << N) - 1));
      req = r;
      push_frame(r);
      gt = grant_cnt;
      dt = done_cnt;
      wait_grants(gt + 1);
      @(posedge clk); #1;
      req = '0;
      rand_frames(1'b1);
      apply_frames();
      wait_dones(dt + 1);
    end
    rdy_mode = 0;

    wait_idle();
    check("grants_left",  32'(exp_grant_q.size()), 32'd0);
    check("dones_left",   32'(exp_done_q.size()),  32'd0);
    check("bytes_left",   32'(exp_byte_q.size()),  32'd0);
    check("lengths_left", 32'(exp_len_q.size()),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
